mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares one unified instruction/data memory between the core's fetch port and load/store port. It accepts level-held requests from each port and grants one at a time, alternating on contention. It drives a single registered request/valid memory bus and returns the response to the granted port. It also raises `core_stall` so the single-cycle core holds its PC and register write-back until both accesses of the current instruction have completed.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles; used only with the macro
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `i_request`  in  1  fetch request, held high until `i_valid`
- `i_we_re`  in  1  fetch write(1)/read(0), normally 0
- `i_mask`  in  4  fetch byte mask
- `i_addr`  in  ADDR_W  fetch address (PC)
- `i_wdata`  in  DATA_W  fetch write data
- `i_valid`  out  1  fetch response strobe
- `i_rdata`  out  DATA_W  fetch read data
- `d_request`  in  1  data request, held high until `d_valid`
- `d_we_re`  in  1  data write(1)/read(0)
- `d_mask`  in  4  data byte mask
- `d_addr`  in  ADDR_W  data address (ALU result)
- `d_wdata`  in  DATA_W  store data
- `d_valid`  out  1  data response strobe
- `d_rdata`  out  DATA_W  load data
- `mem_request`  out  1  memory request, registered
- `mem_we_re`  out  1  memory write/read, registered
- `mem_mask`  out  4  memory byte mask, registered
- `mem_addr`  out  ADDR_W  memory address, registered
- `mem_wdata`  out  DATA_W  memory write data, registered
- `mem_valid`  in  1  memory completion strobe
- `mem_rdata`  in  DATA_W  memory read data
- `core_stall`  out  1  hold core state this cycle
- `err`  out  1  response is a timeout abort; tied 0 without the macro

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D. Register `last_grant` records the port served last.
- IDLE:
  - Only `d_request` high -> SERVE_D.
  - Only `i_request` high -> SERVE_I.
  - Both high -> the port not equal to `last_grant`.
  - Neither high -> stay in IDLE.
- On the transition into SERVE_x:
  - Latch x's `we_re`, `mask`, `addr` and `wdata` into the `mem_*` registers.
  - Set `mem_request` = 1.
  - Set `last_grant` = x.
- SERVE_x with `mem_valid` = 1 (completion):
  - `x_valid` = 1 combinationally that cycle; `x_rdata` = `mem_rdata`.
  - Next state applies the IDLE arbitration to the other port only. If the other port is requesting, go directly to SERVE_other with a new latch; otherwise go to IDLE with `mem_request` = 0.
- `x_valid` is low outside SERVE_x. `i_rdata`/`d_rdata` are don't-care when their valid is low.
- `mem_valid` in IDLE is ignored.
- Requester drops its request mid-transaction: the latched transaction still completes and `x_valid` still pulses.
- `core_stall` = (`i_request` & ~`i_valid`) | (`d_request` & ~`d_valid`).

## Timing
- Reset (`rst` = 0 at a clock edge):
  - State -> IDLE; `last_grant` -> I, so D wins the first tie.
  - All `mem_*` outputs -> 0; `err` -> 0; watchdog count -> 0.
  - `i_valid`/`d_valid` are 0 from the first cycle after the edge.
- Reset mid-transaction: the transaction is abandoned and any later `mem_valid` for it is ignored.
- Latency:
  - Request seen in IDLE at cycle N -> `mem_request` high at N+1.
  - Earliest valid at N+1 (1-cycle minimum with zero-wait memory).
  - Back-to-back contention: the second port's `mem_request` stays high continuously and its fields update on the cycle after the first completion.
- `mem_*` fields stay stable while `mem_request` = 1 and `mem_valid` = 0.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to SERVE_x and increments each SERVE cycle without `mem_valid`.
  - When it reaches `TIMEOUT_CYCLES`, the arbiter forces completion that cycle: `x_valid` = 1, `err` = 1, `x_rdata` = 0.
  - Next state follows the normal completion rule, and `mem_request` drops if going to IDLE.
  - If `mem_valid` arrives in the timeout cycle, it is a normal completion with `err` = 0.
- Not defined: no counter; `err` is constant 0; a transaction waits indefinitely.

## Structure
- Package `mem_arb_pkg`:
  - State enum: IDLE=2'b00, SERVE_I=2'b01, SERVE_D=2'b10.
  - Grant encoding: GNT_I=1'b0, GNT_D=1'b1.
  - Default `TIMEOUT_CYCLES`.
- Sub-module `mem_arb_watchdog`:
  - Ports: clk, rst, clear, run, expired.
  - Counter width $clog2(TIMEOUT_CYCLES+1).
  - Instantiated only under the macro.

## Test plan
- Fetch only, read, zero-wait memory: `i_request` at N with `i_addr`=0x0000_0010 -> `mem_request`=1 and `mem_addr`=0x10 at N+1; `mem_rdata`=0x0000_0013 with `mem_valid` -> `i_valid`=1 and `i_rdata`=0x13 at N+1; state IDLE at N+2.
- Simultaneous requests after reset: I addr 0x20, D store addr 0x100, `d_wdata`=0xCAFE_F00D, mask 4'hF -> D granted first with `mem_we_re`=1; after its `mem_valid`, `mem_addr`=0x20 on the next cycle with `mem_request` held high.
- Alternation: both ports request continuously for 4 transactions -> grant order D, I, D, I.
- Request dropped, then reset: memory with 3 wait states, `d_request` dropped after 1 cycle -> `d_valid` still pulses on `mem_valid`. `rst`=0 during a wait -> `mem_request`=0 next cycle and the late `mem_valid` produces no valid.
- Stall: D load pending 2 wait states -> `core_stall`=1 until the `d_valid` cycle, 0 in that cycle.
- Timeout (macro, `TIMEOUT_CYCLES`=4): memory never responds -> `i_valid`=1, `err`=1, `i_rdata`=0 at the 4th SERVE cycle; `mem_request`=0 next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } arb_state_e;

    // Port identity, used for the last-grant record and for arbitration results.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    // Default watchdog limit in cycles.
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Pick the port to serve among the competing candidates. On a tie the port
    // that was not served last wins; with one candidate that candidate wins.
    // The result is only meaningful when at least one candidate is high.
    function automatic grant_e pick_port(input logic   cand_i,
                                         input logic   cand_d,
                                         input grant_e last);
        grant_e g;
        if (cand_i && cand_d) begin
            if (last == GNT_I) begin
                g = GNT_D;
            end else begin
                g = GNT_I;
            end
        end else if (cand_d) begin
            g = GNT_D;
        end else begin
            g = GNT_I;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Watchdog counter for the arbiter: cleared when a transaction starts, counts
// SERVE cycles spent waiting on memory, and flags the cycle in which the wait
// reaches TIMEOUT_CYCLES. Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Expiry fires in the cycle whose increment would reach the limit, so the
    // abort lands on the TIMEOUT_CYCLES-th waiting cycle.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a new transaction restarts the count, a waiting cycle advances it.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = run && (count_q == LIMIT_M1);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory between the fetch (I) port and the
// load/store (D) port. Grants one port at a time, alternating on contention,
// drives a registered request/valid memory bus and routes the response back.
// Optional watchdog abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    // Fetch port
    input  logic              i_request,
    input  logic              i_we_re,
    input  logic [3:0]        i_mask,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    // Load/store port
    input  logic              d_request,
    input  logic              d_we_re,
    input  logic [3:0]        d_mask,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    // Memory bus
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    // Core control
    output logic              core_stall,
    output logic              err
);

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic              mem_request_q, mem_request_d;
    logic              mem_we_re_q, mem_we_re_d;
    logic [3:0]        mem_mask_q, mem_mask_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              serving_s;
    logic              timeout_s;
    logic              done_s;
    logic              arb_en_s;
    logic              cand_i_s;
    logic              cand_d_s;
    grant_e            pick_s;
    logic              i_valid_s;
    logic              d_valid_s;
    logic [DATA_W-1:0] rsp_data_s;

    assign serving_s = (state_q == SERVE_I) || (state_q == SERVE_D);
    // A transaction ends on a memory completion or on a forced watchdog abort.
    assign done_s    = serving_s && (mem_valid || timeout_s);
    // Aborted transactions return zero data; timeout_s is never high with mem_valid.
    assign rsp_data_s = timeout_s ? {DATA_W{1'b0}} : mem_rdata;

    // Decide who competes for the bus this cycle and which port completes.
    // In IDLE both ports compete; on a completion only the other port does.
    always_comb begin
        arb_en_s  = 1'b0;
        cand_i_s  = 1'b0;
        cand_d_s  = 1'b0;
        i_valid_s = 1'b0;
        d_valid_s = 1'b0;
        case (state_q)
            IDLE: begin
                arb_en_s = 1'b1;
                cand_i_s = i_request;
                cand_d_s = d_request;
            end
            SERVE_I: begin
                if (done_s) begin
                    arb_en_s  = 1'b1;
                    cand_d_s  = d_request;
                    i_valid_s = 1'b1;
                end else begin
                    arb_en_s  = 1'b0;
                end
            end
            SERVE_D: begin
                if (done_s) begin
                    arb_en_s  = 1'b1;
                    cand_i_s  = i_request;
                    d_valid_s = 1'b1;
                end else begin
                    arb_en_s  = 1'b0;
                end
            end
            default: begin
                // Unreachable encoding: arbitrate with no candidates to fall back to IDLE.
                arb_en_s = 1'b1;
            end
        endcase
    end

    assign pick_s = pick_port(cand_i_s, cand_d_s, last_grant_q);

    // Next state, grant record and memory-bus latch. Fields only change on a
    // grant, so they hold steady while a transaction waits on memory.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mem_request_d = mem_request_q;
        mem_we_re_d   = mem_we_re_q;
        mem_mask_d    = mem_mask_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if (arb_en_s) begin
            if (cand_i_s || cand_d_s) begin
                last_grant_d  = pick_s;
                mem_request_d = 1'b1;
                if (pick_s == GNT_D) begin
                    state_d     = SERVE_D;
                    mem_we_re_d = d_we_re;
                    mem_mask_d  = d_mask;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else begin
                    state_d     = SERVE_I;
                    mem_we_re_d = i_we_re;
                    mem_mask_d  = i_mask;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = i_wdata;
                end
            end else begin
                state_d       = IDLE;
                mem_request_d = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and memory-bus registers with synchronous active-low reset; the
    // reset grant record of I makes D win the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_grant_q  <= GNT_I;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_mask_q    <= 4'h0;
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_wdata_q   <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_mask_q    <= mem_mask_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic clear_s;
    logic run_s;
    logic expired_s;

    // A new transaction starts whenever the next state is a SERVE state
    // entered from IDLE or from a completion.
    assign clear_s = ((state_d == SERVE_I) || (state_d == SERVE_D)) &&
                     ((state_q == IDLE) || done_s);
    assign run_s   = serving_s && !mem_valid;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .run     (run_s),
        .expired (expired_s)
    );

    assign timeout_s = expired_s;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_s = 1'b0;
`endif

    assign mem_request = mem_request_q;
    assign mem_we_re   = mem_we_re_q;
    assign mem_mask    = mem_mask_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

    assign i_valid = i_valid_s;
    assign d_valid = d_valid_s;
    assign i_rdata = rsp_data_s;
    assign d_rdata = rsp_data_s;
    assign err     = timeout_s;

    assign core_stall = (i_request & ~i_valid_s) | (d_request & ~d_valid_s);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// two-port traffic checked against a word-array memory reference.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_request = 1'b0, i_we_re = 1'b0;
    logic [3:0]    i_mask = 4'h0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_wdata = '0;
    logic          i_valid;
    logic [DW-1:0] i_rdata;
    logic          d_request = 1'b0, d_we_re = 1'b0;
    logic [3:0]    d_mask = 4'h0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_request, mem_we_re;
    logic [3:0]    mem_mask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          core_stall, err;

    int checks = 0;
    int errors = 0;

    // Reference memory (what the requesters expect) and the memory device image.
    logic [31:0] ref_mem [32];
    logic [31:0] mem_arr [32];
    logic [31:0] rec_addr, rec_wdata;
    logic        rec_we;
    logic [3:0]  rec_mask;
    logic        rand_stop = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .i_request(i_request), .i_we_re(i_we_re), .i_mask(i_mask), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_request(d_request), .d_we_re(d_we_re), .d_mask(d_mask), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .core_stall(core_stall), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        i_request = 1'b0; i_we_re = 1'b0; i_mask = 4'h0; i_addr = '0; i_wdata = '0;
        d_request = 1'b0; d_we_re = 1'b0; d_mask = 4'h0; d_addr = '0; d_wdata = '0;
        mem_valid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0; step(); step(); rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0; step(); step();
        @(negedge clk);
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL reset_mem_request: got %0h want 0", mem_request); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        checks++; if ({mem_we_re, mem_mask} !== 5'h0) begin errors++; $display("FAIL reset_mem_we_mask: got %0h want 0", {mem_we_re, mem_mask}); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
        checks++; if ({i_valid, d_valid, err, core_stall} !== 4'h0) begin errors++; $display("FAIL reset_outputs: got %0h want 0", {i_valid, d_valid, err, core_stall}); end
        step(); rst = 1'b1;
    endtask

    task automatic test_fetch_zero_wait();
        do_reset();
        i_request = 1'b1; i_addr = 32'h0000_0010; i_mask = 4'hF;
        @(negedge clk);
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL fetch_idle_req: got %0h want 0", mem_request); end
        checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL fetch_idle_stall: got %0h want 1", core_stall); end
        step(); mem_valid = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        checks++; if ({mem_request, mem_we_re} !== 2'b10) begin errors++; $display("FAIL fetch_req_we: got %0h want 2", {mem_request, mem_we_re}); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_addr: got %0h want 10", mem_addr); end
        checks++; if ({i_valid, d_valid, core_stall} !== 3'b100) begin errors++; $display("FAIL fetch_valid_stall: got %0h want 4", {i_valid, d_valid, core_stall}); end
        checks++; if (i_rdata !== 32'h13) begin errors++; $display("FAIL fetch_rdata: got %0h want 13", i_rdata); end
        step(); i_request = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        checks++; if ({mem_request, i_valid} !== 2'b00) begin errors++; $display("FAIL fetch_back_idle: got %0h want 0", {mem_request, i_valid}); end
    endtask

    task automatic test_contention();
        do_reset();
        i_request = 1'b1; i_addr = 32'h20; i_mask = 4'hF;
        d_request = 1'b1; d_we_re = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D; d_mask = 4'hF;
        step();
        @(negedge clk);
        checks++; if ({mem_request, mem_we_re, mem_mask} !== 6'b11_1111) begin errors++; $display("FAIL cont_d_first_ctrl: got %0h want 3f", {mem_request, mem_we_re, mem_mask}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL cont_d_first_addr: got %0h want 100", mem_addr); end
        checks++; if (mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL cont_d_wdata: got %0h want cafef00d", mem_wdata); end
        checks++; if ({d_valid, i_valid, core_stall} !== 3'b001) begin errors++; $display("FAIL cont_wait: got %0h want 1", {d_valid, i_valid, core_stall}); end
        step(); mem_valid = 1'b1;
        @(negedge clk);
        checks++; if ({d_valid, i_valid} !== 2'b10) begin errors++; $display("FAIL cont_d_done: got %0h want 2", {d_valid, i_valid}); end
        step(); mem_valid = 1'b0; d_request = 1'b0;
        @(negedge clk);
        checks++; if ({mem_request, mem_we_re} !== 2'b10) begin errors++; $display("FAIL cont_i_held: got %0h want 2", {mem_request, mem_we_re}); end
        checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL cont_i_addr: got %0h want 20", mem_addr); end
        step(); mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if ({i_valid, i_rdata} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL cont_i_done: got %0h want 112345678", {i_valid, i_rdata}); end
        step(); i_request = 1'b0; mem_valid = 1'b0;
    endtask

    task automatic test_alternation();
        logic exp_d;
        do_reset();
        i_request = 1'b1; i_addr = 32'h40; i_mask = 4'hF;
        d_request = 1'b1; d_addr = 32'h200; d_mask = 4'hF;
        mem_valid = 1'b1; mem_rdata = 32'h99;
        @(negedge clk);
        checks++; if ({i_valid, d_valid, mem_request} !== 3'b000) begin errors++; $display("FAIL alt_idle_ignores_valid: got %0h want 0", {i_valid, d_valid, mem_request}); end
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) d_request = 1'b0;
            exp_d = (k % 2) == 1;
            @(negedge clk);
            checks++; if ({d_valid, i_valid, mem_request} !== {exp_d, ~exp_d, 1'b1}) begin errors++; $display("FAIL alt_order_%0d: got %0h want %0h", k, {d_valid, i_valid, mem_request}, {exp_d, ~exp_d, 1'b1}); end
            checks++; if (mem_addr !== (exp_d ? 32'h200 : 32'h40)) begin errors++; $display("FAIL alt_addr_%0d: got %0h want %0h", k, mem_addr, (exp_d ? 32'h200 : 32'h40)); end
        end
        step(); i_request = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL alt_end_idle: got %0h want 0", mem_request); end
    endtask

    task automatic test_drop_and_reset();
        do_reset();
        d_request = 1'b1; d_addr = 32'h40; d_mask = 4'hF;
        step(); d_request = 1'b0;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            checks++; if ({mem_request, d_valid} !== 2'b10) begin errors++; $display("FAIL drop_wait_%0d: got %0h want 2", w, {mem_request, d_valid}); end
            if (w < 2) step();
        end
        step(); mem_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        checks++; if ({d_valid, d_rdata} !== {1'b1, 32'h5555_AAAA}) begin errors++; $display("FAIL drop_still_valid: got %0h want 15555aaaa", {d_valid, d_rdata}); end
        step(); mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL drop_idle: got %0h want 0", mem_request); end
        i_request = 1'b1; i_addr = 32'h80; i_mask = 4'hF;
        step(); step(); rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_request !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %0h want 1", mem_request); end
        step(); rst = 1'b1; i_request = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        checks++; if ({mem_request, i_valid, d_valid} !== 3'b000) begin errors++; $display("FAIL rst_abandon: got %0h want 0", {mem_request, i_valid, d_valid}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_abandon_addr: got %0h want 0", mem_addr); end
        step();
        @(negedge clk);
        checks++; if ({mem_request, i_valid} !== 2'b00) begin errors++; $display("FAIL rst_late_valid: got %0h want 0", {mem_request, i_valid}); end
        mem_valid = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        d_request = 1'b1; d_addr = 32'h48; d_mask = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL stall_pending_%0d: got %0h want 1", c, core_stall); end
            step();
        end
        mem_valid = 1'b1;
        @(negedge clk);
        checks++; if ({core_stall, d_valid} !== 2'b01) begin errors++; $display("FAIL stall_release: got %0h want 1", {core_stall, d_valid}); end
        step(); d_request = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL stall_after: got %0h want 0", core_stall); end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        i_request = 1'b1; i_addr = 32'h30; i_mask = 4'hF; mem_rdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 3; k++) begin
            step();
            @(negedge clk);
            checks++; if ({mem_request, i_valid, err} !== 3'b100) begin errors++; $display("FAIL to_wait_%0d: got %0h want 4", k, {mem_request, i_valid, err}); end
        end
        step();
        @(negedge clk);
        checks++; if ({i_valid, err, i_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL to_abort: got %0h want 300000000", {i_valid, err, i_rdata}); end
        step(); i_request = 1'b0;
        @(negedge clk);
        checks++; if ({mem_request, err, i_valid} !== 3'b000) begin errors++; $display("FAIL to_drop_req: got %0h want 0", {mem_request, err, i_valid}); end
        i_request = 1'b1;
        for (int k = 1; k <= 3; k++) step();
        step(); mem_valid = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        checks++; if ({i_valid, err, i_rdata} !== {2'b10, 32'h77}) begin errors++; $display("FAIL to_race_normal: got %0h want 200000077", {i_valid, err, i_rdata}); end
        step(); i_request = 1'b0; mem_valid = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        i_request = 1'b1; i_addr = 32'h30; i_mask = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            step();
            @(negedge clk);
            checks++; if ({mem_request, i_valid, err} !== 3'b100) begin errors++; $display("FAIL nto_wait_%0d: got %0h want 4", k, {mem_request, i_valid, err}); end
        end
        step(); mem_valid = 1'b1; mem_rdata = 32'h31;
        @(negedge clk);
        checks++; if ({i_valid, err, i_rdata} !== {2'b10, 32'h31}) begin errors++; $display("FAIL nto_done: got %0h want 200000031", {i_valid, err, i_rdata}); end
        step(); i_request = 1'b0; mem_valid = 1'b0;
    endtask
`endif

    // Memory device: random 0..2 wait states, records the bus fields it completes.
    task automatic responder();
        int wcnt, wtarget, idx;
        wcnt = 0; wtarget = int'($urandom_range(0, 2));
        while (!rand_stop) begin
            step();
            if (mem_request === 1'b1) begin
                if (wcnt == wtarget) begin
                    idx = int'(mem_addr[6:2]);
                    rec_addr = mem_addr; rec_we = mem_we_re; rec_mask = mem_mask; rec_wdata = mem_wdata;
                    mem_rdata = mem_arr[idx];
                    if (mem_we_re) mem_arr[idx] = merge(mem_arr[idx], mem_wdata, mem_mask);
                    mem_valid = 1'b1;
                    wcnt = 0; wtarget = int'($urandom_range(0, 2));
                end else begin
                    mem_valid = 1'b0; mem_rdata = $urandom(); wcnt++;
                end
            end else begin
                mem_valid = 1'b0; wcnt = 0;
            end
        end
        mem_valid = 1'b0;
    endtask

    task automatic rand_port_i(input int n);
        int gap, idx;
        logic [31:0] exp_v;
        logic got;
        for (int t = 0; t < n; t++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) step();
            idx = int'($urandom_range(0, 15));
            i_addr = 32'(idx * 4); i_we_re = 1'b0; i_mask = 4'hF; i_wdata = $urandom(); i_request = 1'b1;
            exp_v = ref_mem[idx];
            got = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                @(negedge clk);
                if (i_valid === 1'b1) got = 1'b1; else step();
            end
            checks++;
            if (!got) begin errors++; $display("FAIL rand_i_no_valid: got 0 want 1 (txn %0d)", t); end
            else begin
                if (i_rdata !== exp_v) begin errors++; $display("FAIL rand_i_rdata: got %0h want %0h", i_rdata, exp_v); end
                checks++; if ({rec_addr, rec_we, d_valid} !== {i_addr, 2'b00}) begin errors++; $display("FAIL rand_i_bus: got %0h want %0h", {rec_addr, rec_we, d_valid}, {i_addr, 2'b00}); end
            end
            step(); i_request = 1'b0;
        end
    endtask

    task automatic rand_port_d(input int n);
        int gap, idx;
        logic [31:0] exp_v;
        logic got;
        for (int t = 0; t < n; t++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) step();
            idx = int'($urandom_range(16, 31));
            d_addr = 32'(idx * 4); d_we_re = 1'($urandom_range(0, 1));
            d_mask = 4'($urandom_range(1, 15)); d_wdata = $urandom(); d_request = 1'b1;
            exp_v = ref_mem[idx];
            got = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                @(negedge clk);
                if (d_valid === 1'b1) got = 1'b1; else step();
            end
            checks++;
            if (!got) begin errors++; $display("FAIL rand_d_no_valid: got 0 want 1 (txn %0d)", t); end
            else begin
                if ({rec_addr, rec_we, rec_mask, i_valid} !== {d_addr, d_we_re, d_mask, 1'b0}) begin
                    errors++; $display("FAIL rand_d_bus: got %0h want %0h", {rec_addr, rec_we, rec_mask, i_valid}, {d_addr, d_we_re, d_mask, 1'b0});
                end
                checks++;
                if (d_we_re) begin
                    if (rec_wdata !== d_wdata) begin errors++; $display("FAIL rand_d_wdata: got %0h want %0h", rec_wdata, d_wdata); end
                    ref_mem[idx] = merge(ref_mem[idx], d_wdata, d_mask);
                end else begin
                    if (d_rdata !== exp_v) begin errors++; $display("FAIL rand_d_rdata: got %0h want %0h", d_rdata, exp_v); end
                end
            end
            step(); d_request = 1'b0;
        end
    endtask

    task automatic test_random_traffic();
        for (int k = 0; k < 32; k++) begin
            ref_mem[k] = (32'(k) * 32'h0101_0101) ^ 32'h1357_9BDF;
            mem_arr[k] = ref_mem[k];
        end
        do_reset();
        rand_stop = 1'b0;
        fork
            begin
                fork
                    rand_port_i(24);
                    rand_port_d(24);
                join
                rand_stop = 1'b1;
            end
            responder();
        join
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_contention();
        test_alternation();
        test_drop_and_reset();
        test_stall();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
